// File: rtl/mem_req_ctrl_pkg.sv
// Shared types for the memory request controller: port state and the
// request/response entries that travel through the FIFOs.
package mem_req_ctrl_pkg;

    localparam int PKG_DATA_WIDTH    = 32;
    localparam int PKG_ADDRESS_WIDTH = 12;
    localparam int PKG_TAG_WIDTH     = 4;

    // What the RAM port is doing during the current cycle.
    typedef enum logic [1:0] {
        PORT_IDLE = 2'd0,
        PORT_RD   = 2'd1,
        PORT_WR   = 2'd2
    } port_state_t;

    typedef struct packed {
        logic                         wr;
        logic [PKG_ADDRESS_WIDTH-1:0] addr;
        logic [PKG_DATA_WIDTH-1:0]    wdata;
        logic [PKG_TAG_WIDTH-1:0]     tag;
    } req_entry_t;

    typedef struct packed {
        logic                      wr;
        logic [PKG_DATA_WIDTH-1:0] rdata;
        logic [PKG_TAG_WIDTH-1:0]  tag;
    } resp_entry_t;

endpackage

// File: rtl/mem_fifo.sv
// Synchronous in-order FIFO with occupancy count. DEPTH must be a power of 2.
// Push while full and pop while empty are ignored.
module mem_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = storage[rd_ptr];

    // Pointer and occupancy bookkeeping.
    // NOTE: clocked state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage write.
    // NOTE: the array is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr] <= din;
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// Memory request controller: queues core loads/stores, issues them in order
// to a single-port RAM (registered address/data/write-enable) and returns
// load data through a 2-entry response FIFO with credit-based issue.
// Optional feature: define MEM_STORE_ACK_EN to return an ack response for stores.
module mem_req_ctrl
    import mem_req_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = PKG_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = PKG_ADDRESS_WIDTH,
    parameter int TAG_WIDTH     = PKG_TAG_WIDTH,
    parameter int QDEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_wr,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    input  logic [TAG_WIDTH-1:0]     req_tag,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_wr,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic [TAG_WIDTH-1:0]     resp_tag,
    output logic                     mem_wEn,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_dataIn,
    input  logic [DATA_WIDTH-1:0]    mem_dataOut,
    output logic                     idle
);

    localparam int REQ_W  = $bits(req_entry_t);
    localparam int RESP_W = $bits(resp_entry_t);

    req_entry_t              req_in;
    req_entry_t              req_head;
    logic                    req_push;
    logic                    req_full;
    logic                    req_empty;
    logic [$clog2(QDEPTH):0] req_count;

    resp_entry_t             resp_in;
    resp_entry_t             resp_head;
    logic                    resp_push;
    logic                    resp_pop;
    logic                    resp_full;
    logic                    resp_empty;
    logic [1:0]              resp_count;

    port_state_t             port_state;
    port_state_t             port_next;
    logic [TAG_WIDTH-1:0]    port_tag;
    logic                    port_busy;
    logic [2:0]              credit_need;
    logic                    issue;

    // Occupancy outputs that only matter for debug visibility.
    logic unused_status;
    assign unused_status = ^{req_count, resp_full};

    assign req_in    = '{wr: req_wr, addr: req_addr, wdata: req_wdata, tag: req_tag};
    assign req_push  = req_valid && req_ready;
    assign req_ready = !req_full;

    mem_fifo #(.WIDTH(REQ_W), .DEPTH(QDEPTH)) u_req_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_push),
        .din   (req_in),
        .pop   (issue),
        .dout  (req_head),
        .count (req_count),
        .full  (req_full),
        .empty (req_empty)
    );

    mem_fifo #(.WIDTH(RESP_W), .DEPTH(2)) u_resp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (resp_push),
        .din   (resp_in),
        .pop   (resp_pop),
        .dout  (resp_head),
        .count (resp_count),
        .full  (resp_full),
        .empty (resp_empty)
    );

    // Issue decision, next port state and the response produced by the op now on the port.
    // NOTE: every output of this block is defaulted first so no latch is inferred.
    always_comb begin
        port_busy = (port_state == PORT_RD);
        resp_in   = '{wr: 1'b0, rdata: mem_dataOut, tag: port_tag};
`ifdef MEM_STORE_ACK_EN
        if (port_state == PORT_WR) begin
            port_busy = 1'b1;
            resp_in   = '{wr: 1'b1, rdata: '0, tag: port_tag};
        end
`endif
        resp_push = port_busy;
        resp_pop  = !resp_empty && resp_ready;

        // Responses that will exist or be pending after this edge, excluding the head.
        credit_need = {1'b0, resp_count} + {2'b00, port_busy} - {2'b00, resp_pop};
`ifdef MEM_STORE_ACK_EN
        issue = !req_empty && (credit_need < 3'd2);
`else
        issue = !req_empty && (req_head.wr || (credit_need < 3'd2));
`endif

        port_next = PORT_IDLE;
        if (issue) port_next = req_head.wr ? PORT_WR : PORT_RD;
    end

    // Port state register and the tag of the op on the port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_state <= PORT_IDLE;
            port_tag   <= '0;
        end else begin
            port_state <= port_next;
            if (issue) port_tag <= req_head.tag;
        end
    end

    // Registered RAM interface; address and data hold while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_wEn    <= 1'b0;
            mem_addr   <= '0;
            mem_dataIn <= '0;
        end else begin
            mem_wEn <= issue && req_head.wr;
            if (issue) begin
                mem_addr   <= req_head.addr;
                mem_dataIn <= req_head.wdata;
            end
        end
    end

    assign resp_valid = !resp_empty;
    assign resp_wr    = !resp_empty && resp_head.wr;
    assign resp_rdata = resp_empty ? '0 : resp_head.rdata;
    assign resp_tag   = resp_empty ? '0 : resp_head.tag;
    assign idle       = req_empty && (port_state == PORT_IDLE) && resp_empty;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed self-checking bench for mem_req_ctrl with a negedge-sampling RAM model.
module tb_mem_req_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_tag;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_wr;
    logic [31:0] resp_rdata;
    logic [3:0]  resp_tag;
    logic        mem_wEn;
    logic [11:0] mem_addr;
    logic [31:0] mem_dataIn;
    logic [31:0] mem_dataOut;
    logic        idle;

    int n_cmp = 0;
    int n_err = 0;

    mem_req_ctrl #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .TAG_WIDTH(4), .QDEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_tag     (req_tag),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_wr     (resp_wr),
        .resp_rdata  (resp_rdata),
        .resp_tag    (resp_tag),
        .mem_wEn     (mem_wEn),
        .mem_addr    (mem_addr),
        .mem_dataIn  (mem_dataIn),
        .mem_dataOut (mem_dataOut),
        .idle        (idle)
    );

    always #5 clk = ~clk;

    // RAM model: preload on the first negedge, then write-then-read on every negedge.
    logic [31:0] ram [4096];
    bit          ram_loaded = 1'b0;
    always @(negedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
            ram[12'h000] = 32'h1111_1111;
            ram[12'h010] = 32'hDEAD_BEEF;
            ram[12'hFFF] = 32'hCAFE_F00D;
            for (int i = 0; i < 6; i++) ram[12'h100 + i] = 32'h5000_0000 + i;
            ram_loaded = 1'b1;
        end
        if (mem_wEn) ram[mem_addr] = mem_dataIn;
        mem_dataOut <= ram[mem_addr];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string ctx);
        check({ctx, " req_ready"},  64'(req_ready),  64'd1);
        check({ctx, " resp_valid"}, 64'(resp_valid), 64'd0);
        check({ctx, " resp_wr"},    64'(resp_wr),    64'd0);
        check({ctx, " resp_rdata"}, 64'(resp_rdata), 64'd0);
        check({ctx, " resp_tag"},   64'(resp_tag),   64'd0);
        check({ctx, " mem_wEn"},    64'(mem_wEn),    64'd0);
        check({ctx, " mem_addr"},   64'(mem_addr),   64'd0);
        check({ctx, " mem_dataIn"}, 64'(mem_dataIn), 64'd0);
        check({ctx, " idle"},       64'(idle),       64'd1);
    endtask

    // Present one request and return #1 after the edge that accepted it.
    task automatic send(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                        input logic [3:0] tag);
        int waited = 0;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_tag   = tag;
        req_valid = 1'b1;
        while (!req_ready && waited < 50) begin
            step();
            waited++;
        end
        if (!req_ready) check("send req_ready wait", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  tag;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int wen_cnt;
        int got;
        int got_idx;
        logic [31:0] got_rdata;
        logic [3:0]  got_tag;
        int n;

        vecs[0] = '{wr: 1'b0, addr: 12'h010, wdata: 32'h0,         tag: 4'd3,  exp_rdata: 32'hDEAD_BEEF};
        vecs[1] = '{wr: 1'b0, addr: 12'hFFF, wdata: 32'h0,         tag: 4'd15, exp_rdata: 32'hCAFE_F00D};
        vecs[2] = '{wr: 1'b0, addr: 12'h000, wdata: 32'h0,         tag: 4'd0,  exp_rdata: 32'h1111_1111};
        vecs[3] = '{wr: 1'b1, addr: 12'h0FF, wdata: 32'h0BAD_F00D, tag: 4'd5,  exp_rdata: 32'h0};
        vecs[4] = '{wr: 1'b0, addr: 12'h0FF, wdata: 32'h0,         tag: 4'd9,  exp_rdata: 32'h0BAD_F00D};
        vecs[5] = '{wr: 1'b1, addr: 12'hFFF, wdata: 32'h0000_0001, tag: 4'd7,  exp_rdata: 32'h0};
        vecs[6] = '{wr: 1'b0, addr: 12'hFFF, wdata: 32'h0,         tag: 4'd2,  exp_rdata: 32'h0000_0001};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_wr     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_tag    = '0;
        resp_ready = 1'b1;
        step();
        step();
        check_reset_vals("reset");
        reset = 1'b0;
        step();

        // Single transactions on empty queues, fixed cycle timing.
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].tag);
            step();
            check($sformatf("v%0d issue wEn", i),  64'(mem_wEn),  64'(vecs[i].wr));
            check($sformatf("v%0d issue addr", i), 64'(mem_addr), 64'(vecs[i].addr));
            if (vecs[i].wr) check($sformatf("v%0d issue wdata", i), 64'(mem_dataIn), 64'(vecs[i].wdata));
            step();
            if (!vecs[i].wr) begin
                check($sformatf("v%0d resp_valid", i), 64'(resp_valid), 64'd1);
                check($sformatf("v%0d resp_wr", i),    64'(resp_wr),    64'd0);
                check($sformatf("v%0d resp_rdata", i), 64'(resp_rdata), 64'(vecs[i].exp_rdata));
                check($sformatf("v%0d resp_tag", i),   64'(resp_tag),   64'(vecs[i].tag));
            end else begin
`ifdef MEM_STORE_ACK_EN
                check($sformatf("v%0d ack valid", i), 64'(resp_valid), 64'd1);
                check($sformatf("v%0d ack wr", i),    64'(resp_wr),    64'd1);
                check($sformatf("v%0d ack rdata", i), 64'(resp_rdata), 64'd0);
                check($sformatf("v%0d ack tag", i),   64'(resp_tag),   64'(vecs[i].tag));
`else
                check($sformatf("v%0d store no resp", i), 64'(resp_valid), 64'd0);
                check($sformatf("v%0d store idle", i),    64'(idle),       64'd1);
                check($sformatf("v%0d wEn one cycle", i), 64'(mem_wEn),    64'd0);
`endif
            end
            step();
            check($sformatf("v%0d idle after", i), 64'(idle), 64'd1);
        end

        // Store then load to the same address back-to-back.
        req_wr = 1'b1; req_addr = 12'h020; req_wdata = 32'h1234_5678; req_tag = 4'd1;
        req_valid = 1'b1;
        check("b2b ready", 64'(req_ready), 64'd1);
        step();
        req_wr = 1'b0; req_wdata = 32'h0; req_tag = 4'd4;
        step();
        req_valid = 1'b0;
        wen_cnt = 0; got = 0; got_idx = -1; got_rdata = '0; got_tag = '0;
        for (int c = 0; c < 8; c++) begin
            if (mem_wEn) wen_cnt++;
            if (resp_valid && !resp_wr && got == 0) begin
                got = 1; got_idx = c; got_rdata = resp_rdata; got_tag = resp_tag;
            end
            step();
        end
        check("b2b wEn cycles", 64'(wen_cnt),   64'd1);
        check("b2b load seen",  64'(got),       64'd1);
        check("b2b load lat",   64'(got_idx),   64'd2);
        check("b2b rdata",      64'(got_rdata), 64'h1234_5678);
        check("b2b tag",        64'(got_tag),   64'd4);

        // Six loads with responses blocked: two complete, the rest queue until full.
        resp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_wr = 1'b0; req_addr = 12'h100 + 12'(i); req_tag = 4'(i); req_valid = 1'b1;
            check($sformatf("fill ready %0d", i), 64'(req_ready), 64'd1);
            step();
        end
        req_valid = 1'b0;
        check("fill full", 64'(req_ready), 64'd0);
        step(); step(); step();
        check("hold valid",   64'(resp_valid), 64'd1);
        check("hold tag",     64'(resp_tag),   64'd0);
        check("hold rdata",   64'(resp_rdata), 64'h5000_0000);
        check("third not issued", 64'(mem_addr), 64'h101);
        check("hold ready",   64'(req_ready),  64'd0);
        check("hold busy",    64'(idle),       64'd0);
        resp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            if (resp_valid) begin
                check($sformatf("drain tag %0d", n),   64'(resp_tag),   64'(n));
                check($sformatf("drain rdata %0d", n), 64'(resp_rdata), 64'h5000_0000 + 64'(n));
                n++;
            end
            step();
        end
        check("drain count", 64'(n), 64'd6);
        step();
        check("drain idle", 64'(idle), 64'd1);

        // Reset while a load occupies the port.
        send(1'b0, 12'h010, 32'h0, 4'd6);
        step();
        check("pre-reset in flight", 64'(idle), 64'd0);
        reset = 1'b1;
        #1;
        check_reset_vals("mid-reset");
        step();
        step();
        reset = 1'b0;
        got = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (resp_valid) got++;
        end
        check("reset drops load", 64'(got),  64'd0);
        check("reset idle",       64'(idle), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
